conv_bram_arbiter: RTL and testbench

Single-port arbiter that shares the convolution output BRAM between three requesters: the convolution engine's pixel writer, the host/inference lookup reader, and the display scan-out reader. Grants at most one access per cycle, drives the BRAM port from registers, and returns read data to the correct reader with a one-cycle valid pulse. Sits between the convolution FSM / readout logic and the output BRAM.

---
 rtl/conv_bram_arbiter.sv | 116 +++++++++++
 tb/tb_conv_bram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bram_arbiter.sv
// Shares the single-port convolution output BRAM between the pixel writer,
// the host lookup reader and the display scan-out reader, one access per cycle.
module conv_bram_arbiter #(
  parameter int AW      = 14,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter int MAXWAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_gnt,
  input  logic          h_req,
  input  logic [AW-1:0] h_addr,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          bram_ena,
  output logic          bram_wea,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout,
  output logic          busy
);

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic [3:0]      wait_cnt_p0;
  logic            host_urgent;
  logic            rd_gnt;
  logic [RD_LAT:0] tag_vld_p;
  logic [RD_LAT:0] tag_id_p;   // 1 = display, 0 = host

  assign host_urgent = h_req && (wait_cnt_p0 == MAXW);
  assign rd_gnt      = h_gnt | d_gnt;

  // Grant stage (combinational): starved host, display, writer, host
  always_comb begin
    w_gnt = 1'b0;
    h_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (host_urgent)  h_gnt = 1'b1;
      else if (d_req)   d_gnt = 1'b1;
      else if (w_req)   w_gnt = 1'b1;
      else if (h_req)   h_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_p0 <= 4'd0;
    end else if (!h_req || h_gnt) begin
      wait_cnt_p0 <= 4'd0;
    end else if (wait_cnt_p0 != MAXW) begin
      wait_cnt_p0 <= wait_cnt_p0 + 4'd1;
    end
  end

  // Command stage: BRAM port driven from registers, addr/din hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bram_ena  <= 1'b0;
      bram_wea  <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      bram_ena <= w_gnt | rd_gnt;
      bram_wea <= w_gnt;
      if (w_gnt) begin
        bram_addr <= w_addr;
        bram_din  <= w_data;
      end else if (h_gnt) begin
        bram_addr <= h_addr;
      end else if (d_gnt) begin
        bram_addr <= d_addr;
      end
    end
  end

  // Tag pipe: stage RD_LAT lines up with valid bram_dout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_p <= '0;
      tag_id_p  <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RD_LAT-1:0], rd_gnt};
      tag_id_p  <= {tag_id_p[RD_LAT-1:0], d_gnt};
    end
  end

  // Return stage: capture read data into the owning reader's register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      h_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      h_rvalid <= tag_vld_p[RD_LAT] & ~tag_id_p[RD_LAT];
      d_rvalid <= tag_vld_p[RD_LAT] &  tag_id_p[RD_LAT];
      if (tag_vld_p[RD_LAT] && !tag_id_p[RD_LAT]) h_rdata <= bram_dout;
      if (tag_vld_p[RD_LAT] &&  tag_id_p[RD_LAT]) d_rdata <= bram_dout;
    end
  end

  assign busy = bram_ena | (|tag_vld_p) | h_rvalid | d_rvalid;

endmodule

// File: tb/tb_conv_bram_arbiter.sv
// Bench for conv_bram_arbiter: behavioural BRAM, shadow memory and an
// in-order read scoreboard, plus directed reset/latency/contention cases.
module tb_conv_bram_arbiter;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int RD_LAT  = 1;
  localparam int MAXWAIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_req, h_req, d_req;
  logic [AW-1:0] w_addr, h_addr, d_addr;
  logic [DW-1:0] w_data;
  logic          w_gnt, h_gnt, d_gnt;
  logic [DW-1:0] h_rdata, d_rdata;
  logic          h_rvalid, d_rvalid;
  logic          bram_ena, bram_wea;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_bram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .h_req(h_req), .h_addr(h_addr), .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
  );

  // Behavioural single-port BRAM with RD_LAT cycles of read latency
  logic [DW-1:0] mem     [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] rd_pipe [0:RD_LAT-1]  = '{default: '0};
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wea) mem[bram_addr] <= bram_din;
      else          rd_pipe[0]     <= mem[bram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_dout = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: reads expected in grant order, data from the grant-order shadow
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;
  rd_exp_t       sb [$];
  logic [DW-1:0] shadow [0:(1<<AW)-1] = '{default: '0};

  always @(negedge clk) begin
    rd_exp_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      check("gnt_onehot", {31'b0, (w_gnt & h_gnt) | (w_gnt & d_gnt) | (h_gnt & d_gnt)}, 32'd0);
      check("gnt_no_req", {31'b0, (w_gnt & !w_req) | (h_gnt & !h_req) | (d_gnt & !d_req)}, 32'd0);
      if (h_rvalid || d_rvalid) begin
        check("rv_both", {31'b0, h_rvalid & d_rvalid}, 32'd0);
        if (sb.size() == 0) begin
          check("rv_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rv_port", {31'b0, d_rvalid}, {31'b0, e.id});
          check("rv_data", {24'b0, d_rvalid ? d_rdata : h_rdata}, {24'b0, e.data});
          check("rv_cycle", cyc, e.due);
        end
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("rv_missing", cyc, e.due);
      end
      if (h_gnt) sb.push_back('{id: 1'b0, data: shadow[h_addr], due: cyc + 2 + RD_LAT});
      if (d_gnt) sb.push_back('{id: 1'b1, data: shadow[d_addr], due: cyc + 2 + RD_LAT});
      if (w_gnt) shadow[w_addr] = w_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_starve(input logic [AW-1:0] a, output int waited);
    h_req  = 1'b1;
    h_addr = a;
    waited = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("w_starved", {31'b0, w_gnt}, 32'd0);
      if (h_gnt) begin
        waited = k;
        break;
      end
      step();
      d_addr = AW'($urandom_range(0, 15));
    end
  endtask

  initial begin
    int waited;
    int t0;
    int r;
    bit found;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int t0;
    int r;
    bit found;
    rst = 1'b0;
    w_req = 1'b1; h_req = 1'b1; d_req = 1'b1;
    w_addr = '0; h_addr = '0; d_addr = '0; w_data = 8'h11;

    // Reset with every requester asking
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w_gnt", {31'b0, w_gnt}, 32'd0);
    check("rst_h_gnt", {31'b0, h_gnt}, 32'd0);
    check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    check("rst_h_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rst_ena", {31'b0, bram_ena}, 32'd0);
    check("rst_wea", {31'b0, bram_wea}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", {18'b0, bram_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("first_d_gnt", {29'b0, w_gnt, h_gnt, d_gnt}, 32'b001);
    step();
    w_req = 1'b0; h_req = 1'b0; d_req = 1'b0;
    repeat (5) step();

    // Preload addr 5 = A7 through the writer
    w_req = 1'b1; w_addr = AW'(5); w_data = 8'hA7;
    @(negedge clk);
    check("preload_gnt", {31'b0, w_gnt}, 32'd1);
    step();
    w_req = 1'b0;
    @(negedge clk);
    check("preload_cmd", {bram_ena, bram_wea, 14'b0, bram_din, 2'b0, bram_addr[5:0]},
          {1'b1, 1'b1, 14'b0, 8'hA7, 2'b0, 6'd5});
    repeat (3) step();

    // Single host read with cycle-exact latency
    h_req = 1'b1; h_addr = AW'(5);
    t0 = cyc;
    @(negedge clk);
    check("sr_h_gnt", {31'b0, h_gnt}, 32'd1);
    step();
    h_req = 1'b0;
    @(negedge clk);
    check("sr_cmd", {bram_ena, bram_wea, busy, 15'b0, bram_addr}, {1'b1, 1'b0, 1'b1, 15'b0, 14'd5});
    for (int k = 2; k <= 2 + RD_LAT + 1; k++) begin
      step();
      @(negedge clk);
      check("sr_rvalid_t", {31'b0, h_rvalid}, {31'b0, (cyc == t0 + 2 + RD_LAT)});
      if (cyc == t0 + 2 + RD_LAT) check("sr_rdata", {24'b0, h_rdata}, 32'h0000_00A7);
      if (cyc == t0 + 3 + RD_LAT) check("sr_busy_done", {31'b0, busy}, 32'd0);
    end
    repeat (2) step();

    // Contention: display and writer continuous, host must wait MAXWAIT
    w_req = 1'b1; w_addr = AW'(100); w_data = 8'h55;
    d_req = 1'b1; d_addr = AW'(3);
    host_starve(AW'(7), waited);
    check("h_wait_1", waited, MAXWAIT);
    step();
    host_starve(AW'(5), waited);
    check("h_wait_2", waited, MAXWAIT);
    step();
    h_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("w_after_contention", {31'b0, w_gnt}, 32'd1);
    step();
    w_req = 1'b0;
    repeat (5) step();

    // Write then read-after-write on the display port
    w_req = 1'b1; w_addr = AW'(10); w_data = 8'h3C;
    @(negedge clk);
    check("raw_w_gnt", {31'b0, w_gnt}, 32'd1);
    step();
    w_req = 1'b0; d_req = 1'b1; d_addr = AW'(10);
    @(negedge clk);
    check("raw_d_gnt", {31'b0, d_gnt}, 32'd1);
    step();
    d_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (d_rvalid) begin
        found = 1'b1;
        check("raw_d_rdata", {24'b0, d_rdata}, 32'h0000_003C);
      end else begin
        step();
      end
    end
    check("raw_d_seen", {31'b0, found}, 32'd1);
    repeat (3) step();

    // Interleaved single-requester traffic, one grant per cycle
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 2));
      w_req = (r == 0); h_req = (r == 1); d_req = (r == 2);
      w_addr = AW'(10 + $urandom_range(0, 3));
      h_addr = AW'(10 + $urandom_range(0, 3));
      d_addr = AW'(10 + $urandom_range(0, 3));
      w_data = DW'($urandom);
      @(negedge clk);
      check("il_gnt", {29'b0, w_gnt, h_gnt, d_gnt}, {29'b0, w_req, h_req, d_req});
      step();
    end
    w_req = 1'b0; h_req = 1'b0; d_req = 1'b0;
    repeat (6) step();

    // Completed host read of A7, then a read dropped by reset mid-flight
    h_req = 1'b1; h_addr = AW'(5);
    step();
    h_req = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("pre_rst_h_rdata", {24'b0, h_rdata}, 32'h0000_00A7);
    step();
    h_req = 1'b1; h_addr = AW'(5);
    @(negedge clk);
    check("mf_h_gnt", {31'b0, h_gnt}, 32'd1);
    step();
    h_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("mf_h_rdata", {24'b0, h_rdata}, 32'd0);
    check("mf_ena", {31'b0, bram_ena}, 32'd0);
    check("mf_busy", {31'b0, busy}, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mf_no_rvalid", {30'b0, h_rvalid, busy}, 32'd0);
      step();
    end

    repeat (4) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
